// File: rtl/pg_ctrl_mc.sv
// Multi-channel packet-generator controller: round-robin grant, multi-beat dd send, stall watchdog.
// Define PG_CTRL_STATS_EN to build the completed-packet counter on pkt_count (otherwise tied to 0).
module pg_ctrl_mc #(
  parameter int NUM_CH  = 4,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 64,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] src_valid,
  output logic [NUM_CH-1:0] src_ready,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic              dd_ready,
  output logic              dd_valid,
  output logic              dd_last,
  output logic [CH_W-1:0]   dd_ch,
  output logic [LEN_W-1:0]  beat_idx,
  output logic              generate_packet,
  output logic              busy,
  output logic              timeout_err,
  output logic [15:0]       pkt_count
);

  localparam int SC_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [SC_W-1:0] STALL_LAST = (TIMEOUT > 0) ? SC_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, SEND, ABORT} state_t;

  state_t           state;
  logic [CH_W-1:0]  rr_ptr;
  logic [LEN_W-1:0] len_q;
  logic [SC_W-1:0]  stall_cnt;
  logic             grant_vld;
  logic [CH_W-1:0]  winner;
  logic             last_beat;

  // Channel index a+b wrapped modulo NUM_CH; both operands are already below NUM_CH.
  function automatic logic [CH_W-1:0] ch_add(input logic [CH_W-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= NUM_CH) s = s - NUM_CH;
    return CH_W'(s);
  endfunction

  // Walk from the farthest offset down so the nearest requester at/after rr_ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    winner    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (src_valid[ch_add(rr_ptr, i)]) begin
        grant_vld = 1'b1;
        winner    = ch_add(rr_ptr, i);
      end
    end
  end

  assign src_ready       = (state == IDLE && grant_vld) ? (NUM_CH'(1) << winner) : '0;
  assign last_beat       = (beat_idx == len_q - LEN_W'(1));
  assign dd_valid        = (state == SEND);
  assign dd_last         = (state == SEND) && last_beat;
  assign generate_packet = (state == SEND);
  assign busy            = (state != IDLE);
  assign timeout_err     = (state == ABORT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      dd_ch     <= '0;
      beat_idx  <= '0;
      len_q     <= '0;
      stall_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            dd_ch     <= winner;
            len_q     <= (pkt_len == '0) ? LEN_W'(1) : pkt_len;
            beat_idx  <= '0;
            stall_cnt <= '0;
            rr_ptr    <= ch_add(winner, 1);
            state     <= SEND;
          end
        end
        SEND: begin
          if (dd_ready) begin
            stall_cnt <= '0;
            if (last_beat) state <= IDLE;
            else           beat_idx <= beat_idx + LEN_W'(1);
          end else begin
            stall_cnt <= stall_cnt + SC_W'(1);
            // A ready beat in the final stall cycle wins over the abort.
            if (TIMEOUT != 0 && stall_cnt == STALL_LAST) state <= ABORT;
          end
        end
        ABORT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PG_CTRL_STATS_EN
  logic [15:0] pkt_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                                       pkt_cnt_q <= '0;
    else if (state == SEND && dd_ready && last_beat) pkt_cnt_q <= pkt_cnt_q + 16'd1;
  end

  assign pkt_count = pkt_cnt_q;
`else
  assign pkt_count = 16'd0;
`endif

endmodule

// File: tb/tb_pg_ctrl_mc.sv
// Directed bench for pg_ctrl_mc: beat scoreboard on a TIMEOUT=64 instance, watchdog on a TIMEOUT=4 instance.
module tb_pg_ctrl_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  src_valid, src_ready;
  logic [7:0]  pkt_len, beat_idx;
  logic        dd_ready, dd_valid, dd_last, generate_packet, busy, timeout_err;
  logic [1:0]  dd_ch;
  logic [15:0] pkt_count;

  logic [3:0]  b_src_valid, b_src_ready;
  logic [7:0]  b_pkt_len, b_beat_idx;
  logic        b_dd_ready, b_dd_valid, b_dd_last, b_generate_packet, b_busy, b_timeout_err;
  logic [1:0]  b_dd_ch;
  logic [15:0] b_pkt_count;

  pg_ctrl_mc #(.NUM_CH(4), .LEN_W(8), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_ready(src_ready), .pkt_len(pkt_len),
    .dd_ready(dd_ready), .dd_valid(dd_valid), .dd_last(dd_last), .dd_ch(dd_ch),
    .beat_idx(beat_idx), .generate_packet(generate_packet), .busy(busy),
    .timeout_err(timeout_err), .pkt_count(pkt_count));

  pg_ctrl_mc #(.NUM_CH(4), .LEN_W(8), .TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst), .src_valid(b_src_valid), .src_ready(b_src_ready), .pkt_len(b_pkt_len),
    .dd_ready(b_dd_ready), .dd_valid(b_dd_valid), .dd_last(b_dd_last), .dd_ch(b_dd_ch),
    .beat_idx(b_beat_idx), .generate_packet(b_generate_packet), .busy(b_busy),
    .timeout_err(b_timeout_err), .pkt_count(b_pkt_count));

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] idx;
    logic       last;
  } beat_t;

  beat_t sb[$];
  int errors = 0;
  int checks = 0;
  int pkts_a = 0;
  int pkts_b = 0;
  int ncyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef PG_CTRL_STATS_EN
    return 32'(16'(n));
`else
    return 32'(n * 0);
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pkt(input int ch, input int len);
    int l;
    beat_t b;
    l = (len == 0) ? 1 : len;
    for (int i = 0; i < l; i++) begin
      b.ch   = 2'(ch);
      b.idx  = 8'(i);
      b.last = (i == l - 1);
      sb.push_back(b);
    end
  endtask

  // Compares every accepted beat against the queue; returns before the edge that takes the last beat.
  task automatic pump(input int budget, output int nvalid);
    beat_t b;
    nvalid = 0;
    for (int i = 0; i < budget; i++) begin
      #1;
      if (dd_valid) nvalid++;
      if (dd_valid && dd_ready) begin
        if (sb.size() == 0) begin
          chk("sb_extra_beat", 32'd1, 32'd0);
        end else begin
          b = sb.pop_front();
          chk("beat_ch",   32'(dd_ch),    32'(b.ch));
          chk("beat_idx",  32'(beat_idx), 32'(b.idx));
          chk("beat_last", 32'(dd_last),  32'(b.last));
          chk("beat_gen",  32'(generate_packet), 32'd1);
          if (sb.size() == 0) return;
        end
      end
      step();
    end
    chk("sb_drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    src_valid = '0; pkt_len = '0; dd_ready = 1'b0;
    b_src_valid = '0; b_pkt_len = '0; b_dd_ready = 1'b0;
    step();
    step();
    #1;
    chk("rst_src_ready", 32'(src_ready), 32'd0);
    chk("rst_dd_valid",  32'(dd_valid),  32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_beat_idx",  32'(beat_idx),  32'd0);
    chk("rst_dd_ch",     32'(dd_ch),     32'd0);
    chk("rst_timeout",   32'(timeout_err), 32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    rst = 1'b0;
    step();

    // Single 3-beat packet on ch0
    src_valid = 4'b0001; pkt_len = 8'd3; dd_ready = 1'b1;
    #1;
    chk("t1_grant", 32'(src_ready), 32'h1);
    expect_pkt(0, 3);
    step();
    src_valid = '0;
    chk("t1_first_valid", 32'(dd_valid), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    pump(20, ncyc);
    chk("t1_send_cycles", 32'(ncyc), 32'd3);
    step();
    pkts_a++;
    chk("t1_idle", 32'(busy), 32'd0);
    chk("t1_pkt_count", 32'(pkt_count), exp_cnt(pkts_a));

    // Round-robin over four requesters from a fresh pointer
    rst = 1'b1;
    step();
    rst = 1'b0;
    pkts_a = 0;
    src_valid = 4'hF; pkt_len = 8'd1; dd_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      #1;
      chk("rr_grant", 32'(src_ready), 32'(4'b0001 << (g % 4)));
      expect_pkt(g % 4, 1);
      step();
      chk("rr_no_b2b", 32'(src_ready), 32'd0);
      chk("rr_valid", 32'(dd_valid), 32'd1);
      pump(20, ncyc);
      step();
      pkts_a++;
    end
    src_valid = '0;
    #1;
    chk("rr_pkt_count", 32'(pkt_count), exp_cnt(pkts_a));

    // Stall on beat 0 for five cycles, below the watchdog limit
    src_valid = 4'b0001; pkt_len = 8'd2;
    #1;
    chk("st_grant", 32'(src_ready), 32'h1);
    expect_pkt(0, 2);
    step();
    src_valid = '0; dd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("st_hold_valid", 32'(dd_valid), 32'd1);
      chk("st_hold_ch",    32'(dd_ch),    32'd0);
      chk("st_hold_idx",   32'(beat_idx), 32'd0);
      chk("st_no_timeout", 32'(timeout_err), 32'd0);
      step();
    end
    dd_ready = 1'b1;
    pump(20, ncyc);
    step();
    pkts_a++;
    chk("st_idle", 32'(busy), 32'd0);
    chk("st_no_timeout_end", 32'(timeout_err), 32'd0);
    chk("st_pkt_count", 32'(pkt_count), exp_cnt(pkts_a));

    // Watchdog: four stall cycles abort
    b_src_valid = 4'b0001; b_pkt_len = 8'd2; b_dd_ready = 1'b0;
    #1;
    chk("wd_grant", 32'(b_src_ready), 32'h1);
    step();
    b_src_valid = '0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("wd_valid", 32'(b_dd_valid), 32'd1);
      chk("wd_no_err_yet", 32'(b_timeout_err), 32'd0);
      step();
    end
    chk("wd_err", 32'(b_timeout_err), 32'd1);
    chk("wd_abort_valid", 32'(b_dd_valid), 32'd0);
    chk("wd_abort_gen", 32'(b_generate_packet), 32'd0);
    chk("wd_abort_busy", 32'(b_busy), 32'd1);
    step();
    chk("wd_err_pulse", 32'(b_timeout_err), 32'd0);
    chk("wd_idle", 32'(b_busy), 32'd0);
    chk("wd_pkt_count", 32'(b_pkt_count), exp_cnt(pkts_b));

    // Watchdog: ready arrives in the last stall cycle, beat wins
    b_src_valid = 4'b0001;
    #1;
    chk("wd2_grant", 32'(b_src_ready), 32'h1);
    step();
    b_src_valid = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wd2_valid", 32'(b_dd_valid), 32'd1);
      step();
    end
    b_dd_ready = 1'b1;
    #1;
    chk("wd2_beat0", 32'(b_beat_idx), 32'd0);
    step();
    chk("wd2_no_err", 32'(b_timeout_err), 32'd0);
    chk("wd2_valid1", 32'(b_dd_valid), 32'd1);
    chk("wd2_beat1", 32'(b_beat_idx), 32'd1);
    chk("wd2_last", 32'(b_dd_last), 32'd1);
    step();
    pkts_b++;
    chk("wd2_idle", 32'(b_busy), 32'd0);
    chk("wd2_pkt_count", 32'(b_pkt_count), exp_cnt(pkts_b));
    b_dd_ready = 1'b0;

    // Reset during beat 1 of a 4-beat packet on ch2
    src_valid = 4'b0100; pkt_len = 8'd4; dd_ready = 1'b1;
    #1;
    chk("mr_grant", 32'(src_ready), 32'h4);
    step();
    src_valid = '0;
    chk("mr_ch", 32'(dd_ch), 32'd2);
    step();
    chk("mr_beat1", 32'(beat_idx), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    pkts_a = 0;
    pkts_b = 0;
    chk("mr_valid", 32'(dd_valid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_idx", 32'(beat_idx), 32'd0);
    chk("mr_ch0", 32'(dd_ch), 32'd0);
    chk("mr_gen", 32'(generate_packet), 32'd0);
    chk("mr_err", 32'(timeout_err), 32'd0);
    chk("mr_cnt", 32'(pkt_count), 32'd0);

    // Pointer back at 0, and a zero length runs as one beat
    src_valid = 4'hF; pkt_len = 8'd0;
    #1;
    chk("mr_regrant_ch0", 32'(src_ready), 32'h1);
    expect_pkt(0, 0);
    step();
    src_valid = '0;
    pump(20, ncyc);
    chk("len0_cycles", 32'(ncyc), 32'd1);
    step();
    pkts_a++;
    chk("len0_idle", 32'(busy), 32'd0);
    chk("len0_pkt_count", 32'(pkt_count), exp_cnt(pkts_a));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
